// File: rtl/pk_frame_tx.sv
// pk_frame_tx: transmit end of the packed-frame interface.
//
// Takes one multi-dimensional packed frame per valid/ready handshake and
// sends it as OUTER beats of SLICE_W bits, most-significant slice first.
// Each beat carries first/last markers and an even-parity bit. A frame that
// carries X/Z bits is dropped and flagged; this check exists only in
// simulation and is constant false in synthesis.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst_n       synchronous reset, active low
//   in_valid    upstream frame valid
//   in_ready    frame accepted when in_valid && in_ready
//   in_frame    packed frame, slice OUTER-1 goes out first
//   out_valid   beat valid
//   out_ready   downstream ready, beat moves when out_valid && out_ready
//   out_data    current slice
//   out_first   beat carries slice OUTER-1
//   out_last    beat carries slice 0
//   out_parity  XOR-reduce of out_data
//   err_xz      one-cycle pulse: an accepted frame held X/Z and was dropped
//   frame_cnt   saturating count of fully transmitted frames
//
// state | meaning
// IDLE  | no frame held, in_ready high
// SEND  | frame held, beat frame_q[idx] presented on out_*

module pk_frame_tx #(
    parameter int OUTER   = 4,
    parameter int SLICE_W = 20,
    parameter int CNT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [OUTER-1:0][SLICE_W-1:0]    in_frame,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SLICE_W-1:0]               out_data,
    output logic                             out_first,
    output logic                             out_last,
    output logic                             out_parity,
    output logic                             err_xz,
    output logic [CNT_W-1:0]                 frame_cnt
);

    localparam int IDX_W = (OUTER > 1) ? $clog2(OUTER) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(OUTER - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic [OUTER-1:0][SLICE_W-1:0]   frame_q;

    logic beat_xfer;
    logic frame_done;
    logic accept;
    logic frame_bad;
    logic load;
    logic reject;

    assign beat_xfer  = out_valid && out_ready;
    // out_last is a register, so this is the only out_ready -> in_ready path.
    assign frame_done = beat_xfer && out_last;
    assign in_ready   = rst_n && ((state == IDLE) || frame_done);
    assign accept     = in_valid && in_ready;

    always_comb begin
        frame_bad = 1'b0;
`ifndef SYNTHESIS
        frame_bad = ((^in_frame) === 1'bx);
`endif
    end

    assign load   = accept && !frame_bad;
    assign reject = accept && frame_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            frame_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_parity <= 1'b0;
            err_xz     <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            err_xz <= reject;

            if (frame_done && (frame_cnt != {CNT_W{1'b1}})) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (load) begin
                // Covers both IDLE accepts and the no-bubble restart on the
                // last beat of the previous frame.
                state      <= SEND;
                frame_q    <= in_frame;
                idx        <= IDX_TOP;
                out_valid  <= 1'b1;
                out_data   <= in_frame[OUTER-1];
                out_first  <= 1'b1;
                out_last   <= 1'b0;
                out_parity <= ^in_frame[OUTER-1];
            end else if (state == SEND && beat_xfer) begin
                if (idx == '0) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    idx        <= idx - IDX_ONE;
                    out_data   <= frame_q[idx - IDX_ONE];
                    out_first  <= 1'b0;
                    out_last   <= (idx == IDX_ONE);
                    out_parity <= ^frame_q[idx - IDX_ONE];
                end
            end
        end
    end

`ifndef SYNTHESIS
    initial begin
        if (OUTER < 2) $fatal(1, "pk_frame_tx: OUTER must be at least 2");
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_first && out_last) begin
            $error("pk_frame_tx: first and last marked on the same beat");
        end
    end
`endif

endmodule

// File: tb/tb_pk_frame_tx.sv
module tb_pk_frame_tx;

    localparam int OUTER   = 4;
    localparam int SLICE_W = 20;

    typedef logic [OUTER-1:0][SLICE_W-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    frame_t in_frame = '0;

    logic               in_ready, out_valid, out_first, out_last, out_parity, err_xz;
    logic [SLICE_W-1:0] out_data;
    logic [7:0]         frame_cnt;

    logic               in_ready2, out_valid2, out_first2, out_last2, out_parity2, err_xz2;
    logic [SLICE_W-1:0] out_data2;
    logic [1:0]         frame_cnt2;

    always #5 clk = ~clk;

    pk_frame_tx #(.OUTER(OUTER), .SLICE_W(SLICE_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_frame(in_frame), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first), .out_last(out_last),
        .out_parity(out_parity), .err_xz(err_xz), .frame_cnt(frame_cnt)
    );

    pk_frame_tx #(.OUTER(OUTER), .SLICE_W(SLICE_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_frame(in_frame), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_first(out_first2), .out_last(out_last2),
        .out_parity(out_parity2), .err_xz(err_xz2), .frame_cnt(frame_cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the frame in flight is a queue of slices still to go.
    logic [SLICE_W-1:0] q[$];
    int   m_cnt  = 0;
    int   m_cnt2 = 0;
    logic m_err  = 1'b0;

    // Values sampled in the most recent cycle, for directed literal checks.
    logic [SLICE_W-1:0] s_data;
    logic s_valid, s_par, s_first, s_last, s_ready, s_err;
    logic [7:0] s_cnt;
    logic [1:0] s_cnt2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic rn, input logic v, input frame_t f,
                         input logic ordy, output logic acc);
        logic busy, rdy;
        @(negedge clk);
        rst_n     = rn;
        in_valid  = v;
        in_frame  = f;
        out_ready = ordy;
        #1;
        s_data = out_data; s_valid = out_valid; s_par = out_parity;
        s_first = out_first; s_last = out_last; s_ready = in_ready;
        s_err = err_xz; s_cnt = frame_cnt; s_cnt2 = frame_cnt2;

        busy = (q.size() > 0);
        rdy  = rn && (!busy || (ordy && q.size() == 1));
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, busy);
        chk("out_valid_w2", out_valid2, busy);
        chk("err_xz", err_xz, m_err);
        chk("frame_cnt", frame_cnt, 64'(m_cnt));
        chk("frame_cnt_w2", frame_cnt2, 64'(m_cnt2));
        if (busy) begin
            chk("out_data", out_data, q[0]);
            chk("out_first", out_first, q.size() == OUTER);
            chk("out_last", out_last, q.size() == 1);
            chk("out_parity", out_parity, ^q[0]);
        end
        acc = v && rdy;

        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (busy && ordy) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
            if (acc) begin
                if ((^f) === 1'bx) m_err = 1'b1;
                else for (int i = OUTER - 1; i >= 0; i--) q.push_back(f[i]);
            end
        end
    endtask

    task automatic send(input frame_t f);
        logic acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, 1'b1, f, 1'b1, acc);
            n++;
        end while (!acc && n < 20);
        chk("send_accept", acc, 1'b1);
        n = 0;
        while (q.size() > 0 && n < 50) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            n++;
        end
        chk("send_drain", q.size(), 0);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < OUTER; i++) f[i] = SLICE_W'($urandom());
        return f;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        frame_t f1, fa, fb, fx;
        logic [SLICE_W-1:0] beats[4];
        logic par[4];
        int sat_exp[5];
        int n;

        beats = '{20'hABCDE, 20'h12345, 20'h00000, 20'hFFFFF};
        par   = '{1'b1, 1'b1, 1'b0, 1'b0};
        sat_exp = '{1, 2, 3, 3, 3};
        f1 = {20'hABCDE, 20'h12345, 20'h00000, 20'hFFFFF};

        repeat (2) @(posedge clk);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, acc);
        cycle(1'b0, 1'b1, f1, 1'b1, acc);
        chk("rst_in_ready", s_ready, 1'b0);
        chk("rst_out_data", s_data, 0);
        chk("rst_out_valid", s_valid, 1'b0);
        chk("rst_cnt", s_cnt, 0);

        // Single frame, full rate
        cycle(1'b1, 1'b1, f1, 1'b1, acc);
        chk("single_accept", acc, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            chk("single_valid", s_valid, 1'b1);
            chk("single_data", s_data, beats[i]);
            chk("single_par", s_par, par[i]);
            chk("single_first", s_first, i == 0);
            chk("single_last", s_last, i == 3);
        end
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        chk("single_idle", s_valid, 1'b0);
        chk("single_cnt", s_cnt, 1);

        // Backpressure during beat 12345
        cycle(1'b1, 1'b1, f1, 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, acc);
            chk("bp_data", s_data, 20'h12345);
            chk("bp_par", s_par, 1'b1);
        end
        n = 0;
        while (q.size() > 0 && n < 20) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            n++;
        end
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        chk("bp_cnt", s_cnt, 2);

        // Back-to-back frames with in_valid held high
        fa = rand_frame();
        fb = rand_frame();
        cycle(1'b1, 1'b1, fa, 1'b1, acc);
        chk("b2b_accept_a", acc, 1'b1);
        n = 0;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, (n == 0) ? fb : rand_frame(), 1'b1, acc);
            chk("b2b_no_gap", s_valid, 1'b1);
            chk("b2b_ready", s_ready, i == 3 || i == 7);
            if (acc && n == 0) n = 1;
            else if (acc) begin
                // a third frame slipped in on the last beat; let it drain
                n = 2;
            end
        end
        n = 0;
        while (q.size() > 0 && n < 20) begin
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            n++;
        end

        // X/Z frame is dropped, next clean frame goes through
        fx = rand_frame();
        fx[2][7] = 1'bz;
        send(fx);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        chk("xz_err_once", s_err, 1'b0);
        send(rand_frame());

        // Reset after the second beat
        cycle(1'b1, 1'b1, rand_frame(), 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        cycle(1'b0, 1'b1, rand_frame(), 1'b1, acc);
        chk("mid_rst_ready", s_ready, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        chk("mid_rst_valid", s_valid, 1'b0);
        chk("mid_rst_cnt", s_cnt, 0);
        chk("mid_rst_ready_rel", s_ready, 1'b1);
        send(rand_frame());

        // Saturation of the 2-bit counter
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            send(rand_frame());
            cycle(1'b1, 1'b0, '0, 1'b1, acc);
            chk("sat_cnt", s_cnt2, 64'(sat_exp[i]));
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            frame_t f;
            logic rn, v, r;
            rn = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 3) != 0);
            f  = rand_frame();
            if ($urandom_range(0, 15) == 0) begin
                f[$urandom_range(0, OUTER - 1)][$urandom_range(0, SLICE_W - 1)] =
                    ($urandom_range(0, 1) != 0) ? 1'bx : 1'bz;
            end
            cycle(rn, v, f, r, acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
